// File: rtl/cpu_fetch_unit.sv
// Instruction fetch sequencer: one outstanding read at a time into a small in-order
// instruction queue. Branch redirects flush the queue and reload the PC register.
module cpu_fetch_unit #(
  parameter int QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pc_in,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic [15:0] pc_ld_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        branch_valid,
  input  logic [15:0] branch_target,
  output logic        ir_valid,
  output logic [15:0] ir_data,
  output logic [15:0] ir_pc,
  input  logic        ir_ready
);

  // QUEUE_DEPTH is 2 or 4, so the pointers wrap naturally at their width.
  localparam int PTR_W = (QUEUE_DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INC   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic        mem_req_next;
  logic [15:0] mem_addr_next;
  logic        pc_inc_next;
  logic        pc_ld_next;
  logic [15:0] pc_ld_data_next;

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [15:0]      q_data [QUEUE_DEPTH];
  logic [15:0]      q_pc   [QUEUE_DEPTH];

  logic fetch_start;
  logic push;
  logic pop;
  logic flush;

  // A new fetch waits until any PC update from the previous one has landed.
  assign fetch_start = (state_reg == IDLE) && (count_reg < DEPTH_C) &&
                       !pc_ld && !pc_inc && !branch_valid;
  assign push  = (state_reg == REQ) && mem_ack && !branch_valid;
  assign flush = branch_valid;
  assign pop   = ir_valid && ir_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (fetch_start) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_next = branch_valid ? IDLE : INC;
        end else if (branch_valid) begin
          state_next = DRAIN;
        end
      end
      INC: begin
        state_next = IDLE;
      end
      DRAIN: begin
        // The redirected read must still complete; its data is thrown away.
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req_next    = (state_next == REQ) || (state_next == DRAIN);
    mem_addr_next   = fetch_start ? pc_in : mem_addr;
    pc_inc_next     = (state_next == INC);
    pc_ld_next      = branch_valid;
    pc_ld_data_next = branch_valid ? branch_target : pc_ld_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      pc_inc     <= 1'b0;
      pc_ld      <= 1'b0;
      pc_ld_data <= '0;
    end else begin
      mem_req    <= mem_req_next;
      mem_addr   <= mem_addr_next;
      pc_inc     <= pc_inc_next;
      pc_ld      <= pc_ld_next;
      pc_ld_data <= pc_ld_data_next;
    end
  end

  // Flush wins over push and pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr_reg] <= mem_rdata;
      q_pc[wr_ptr_reg]   <= mem_addr;
    end
  end

  // Head is masked when empty so the outputs read zero out of reset.
  assign ir_valid = (count_reg != '0);
  assign ir_data  = ir_valid ? q_data[rd_ptr_reg] : '0;
  assign ir_pc    = ir_valid ? q_pc[rd_ptr_reg]   : '0;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: PC register and memory environment, queue-level
// reference model, directed scenarios followed by a randomized run.
module tb_cpu_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc_in;
  logic        pc_inc;
  logic        pc_ld;
  logic [15:0] pc_ld_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        ir_valid;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  cpu_fetch_unit #(.QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .pc_inc(pc_inc),
    .pc_ld(pc_ld),
    .pc_ld_data(pc_ld_data),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .branch_valid(branch_valid),
    .branch_target(branch_target),
    .ir_valid(ir_valid),
    .ir_data(ir_data),
    .ir_pc(ir_pc),
    .ir_ready(ir_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] data;
  } entry_t;

  entry_t      model_q[$];
  logic [15:0] pc_reg;
  logic [15:0] req_addr;
  bit          req_live;
  bit          lat_rand;
  bit          started;
  int          lat;
  int          wait_cnt;
  int          cyc;
  int          last_start;
  int          n_starts;
  int          n_assert;
  int          n_fail;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_mem_req"},    32'(mem_req),    32'h0);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'h0);
    check({tag, "_pc_inc"},     32'(pc_inc),     32'h0);
    check({tag, "_pc_ld"},      32'(pc_ld),      32'h0);
    check({tag, "_pc_ld_data"}, 32'(pc_ld_data), 32'h0);
    check({tag, "_ir_valid"},   32'(ir_valid),   32'h0);
    check({tag, "_ir_data"},    32'(ir_data),    32'h0);
    check({tag, "_ir_pc"},      32'(ir_pc),      32'h0);
  endtask

  // One clock: snapshot, edge, update environment and model, compare.
  task automatic cycle();
    logic        p_req, p_ack, p_bv, p_inc, p_ld, p_rdy;
    logic [15:0] p_addr, p_rdata, p_tgt, p_pc, p_ld_data;
    int          p_qsize;
    bit          live_before, exp_inc;
    p_req = mem_req;  p_ack = mem_ack;  p_bv = branch_valid;
    p_inc = pc_inc;   p_ld = pc_ld;     p_rdy = ir_ready;
    p_addr = mem_addr; p_rdata = mem_rdata; p_tgt = branch_target;
    p_pc = pc_in;     p_ld_data = pc_ld_data;
    p_qsize = model_q.size();
    live_before = req_live;
    @(posedge clk);
    #1;
    cyc++;
    branch_valid = 1'b0;
    if (p_ld) pc_reg = p_ld_data;
    else if (p_inc) pc_reg = pc_reg + 16'd1;
    pc_in = pc_reg;

    exp_inc = p_req && p_ack && live_before && !p_bv;
    if (p_bv) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && p_rdy) void'(model_q.pop_front());
      if (exp_inc) model_q.push_back({req_addr, p_rdata});
    end
    if (p_req && (p_bv || p_ack)) req_live = 0;

    check("pc_inc", 32'(pc_inc), 32'(exp_inc));
    check("pc_ld", 32'(pc_ld), 32'(p_bv));
    if (p_bv) check("pc_ld_data", 32'(pc_ld_data), 32'(p_tgt));
    check("inc_ld_exclusive", 32'(pc_inc & pc_ld), 32'h0);
    if (p_req && !p_ack) begin
      check("req_hold", 32'(mem_req), 32'h1);
      check("addr_hold", 32'(mem_addr), 32'(p_addr));
    end
    if (p_req && p_ack) check("req_drop", 32'(mem_req), 32'h0);
    check("ir_valid", 32'(ir_valid), 32'(model_q.size() != 0));
    if (model_q.size() != 0) begin
      check("ir_pc", 32'(ir_pc), 32'(model_q[0].pc));
      check("ir_data", 32'(ir_data), 32'(model_q[0].data));
    end

    started = mem_req && !p_req;
    if (started) begin
      check("fetch_addr", 32'(mem_addr), 32'(p_pc));
      check("fetch_pc_quiet", 32'({p_ld, p_inc, p_bv}), 32'h0);
      check("fetch_room", 32'(p_qsize < DEPTH), 32'h1);
      check("fetch_gap", 32'((cyc - last_start) >= 3), 32'h1);
      last_start = cyc;
      n_starts++;
      req_live = 1;
      req_addr = p_pc;
      wait_cnt = lat_rand ? int'($urandom_range(0, 3)) : lat;
    end else if (mem_req && wait_cnt > 0) begin
      wait_cnt--;
    end
    mem_ack = mem_req && (wait_cnt == 0);
    mem_rdata = mem_ack ? mem_word(req_addr) : 16'($urandom);
  endtask

  task automatic wait_start(input string tag);
    bit found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle();
      found = started;
    end
    check({tag, "_timeout"}, 32'(found), 32'h1);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      found = ir_valid;
    end
    check({tag, "_timeout"}, 32'(found), 32'h1);
  endtask

  task automatic branch(input logic [15:0] tgt);
    branch_valid = 1'b1;
    branch_target = tgt;
    cycle();
  endtask

  initial begin
    int s0;
    reset = 1'b0;
    pc_reg = 16'h0010; pc_in = pc_reg;
    mem_ack = 1'b0; mem_rdata = '0;
    branch_valid = 1'b0; branch_target = '0; ir_ready = 1'b1;
    lat = 2; lat_rand = 0; wait_cnt = 0; req_live = 0; req_addr = '0;
    cyc = 0; last_start = -100; n_starts = 0; n_assert = 0; n_fail = 0; started = 0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 outputs_zero("reset");
    @(negedge clk) reset = 1'b0;

    // Sequential fetch from 0x0010, ack two cycles after request.
    wait_start("t1_start");
    check("t1_mem_addr", 32'(mem_addr), 32'h0010);
    wait_valid("t1_valid");
    check("t1_ir_pc", 32'(ir_pc), 32'h0010);
    check("t1_ir_data", 32'(ir_data), 32'(mem_word(16'h0010)));
    check("t1_pc_inc", 32'(pc_inc), 32'h1);
    cycle();
    check("t1_pc_inc_pulse", 32'(pc_inc), 32'h0);
    wait_start("t1_next");
    check("t1_next_addr", 32'(mem_addr), 32'h0011);

    // Backpressure: two fetches fill the queue, then one pop allows one more.
    ir_ready = 1'b0;
    s0 = n_starts;
    branch(16'h0100);
    repeat (40) cycle();
    check("t2_two_fetches", 32'(n_starts - s0), 32'h2);
    check("t2_mem_req_idle", 32'(mem_req), 32'h0);
    check("t2_head", 32'(ir_pc), 32'h0100);
    ir_ready = 1'b1;
    cycle();
    ir_ready = 1'b0;
    check("t2_head_after_pop", 32'(ir_pc), 32'h0101);
    s0 = n_starts;
    repeat (20) cycle();
    check("t2_one_refetch", 32'(n_starts - s0), 32'h1);

    // Branch while waiting on a read at 0x0012; ack three cycles after branch.
    ir_ready = 1'b1;
    lat = 4;
    branch(16'h0012);
    wait_start("t3_start");
    check("t3_addr", 32'(mem_addr), 32'h0012);
    cycle();
    branch(16'h0200);
    check("t3_pc_ld", 32'(pc_ld), 32'h1);
    check("t3_pc_ld_data", 32'(pc_ld_data), 32'h0200);
    check("t3_flushed", 32'(ir_valid), 32'h0);
    check("t3_drain_req", 32'(mem_req), 32'h1);
    lat = 2;
    cycle();
    check("t3_pc_ld_pulse", 32'(pc_ld), 32'h0);
    wait_start("t3_restart");
    check("t3_new_addr", 32'(mem_addr), 32'h0200);
    check("t3_no_enqueue", 32'(ir_valid), 32'h0);

    // Branch in the same cycle as the ack of the 0x0200 read.
    cycle();
    cycle();
    branch(16'h0300);
    check("t4_no_inc", 32'(pc_inc), 32'h0);
    check("t4_pc_ld", 32'(pc_ld), 32'h1);
    check("t4_pc_ld_data", 32'(pc_ld_data), 32'h0300);
    check("t4_no_push", 32'(ir_valid), 32'h0);
    check("t4_req_drop", 32'(mem_req), 32'h0);

    // One queued entry; ack and pop land on the same edge.
    ir_ready = 1'b0;
    branch(16'h0400);
    wait_start("t5_first");
    wait_valid("t5_first_push");
    check("t5_first_head", 32'(ir_pc), 32'h0400);
    wait_start("t5_second");
    check("t5_second_addr", 32'(mem_addr), 32'h0401);
    cycle();
    cycle();
    ir_ready = 1'b1;
    cycle();
    check("t5_valid", 32'(ir_valid), 32'h1);
    check("t5_head", 32'(ir_pc), 32'h0401);
    check("t5_head_data", 32'(ir_data), 32'(mem_word(16'h0401)));
    cycle();
    check("t5_drained", 32'(ir_valid), 32'h0);

    // Asynchronous reset in the middle of a read, then a stale ack.
    lat = 6;
    wait_start("t6_start");
    check("t6_addr", 32'(mem_addr), 32'h0402);
    cycle();
    #2 reset = 1'b1;
    #1 outputs_zero("t6_async");
    model_q.delete();
    req_live = 0; wait_cnt = 0; mem_ack = 1'b0; lat = 2;
    repeat (2) @(posedge clk);
    #1 outputs_zero("t6_held");
    @(negedge clk);
    reset = 1'b0;
    last_start = -100;
    mem_ack = 1'b1;
    mem_rdata = 16'hDEAD;
    cycle();
    check("t6_stale_ack", 32'(ir_valid), 32'h0);
    check("t6_restart", 32'(mem_req), 32'h1);
    check("t6_refetch_addr", 32'(mem_addr), 32'h0402);

    // Back-to-back branches: second target wins; then address wrap.
    lat = 0;
    branch(16'h1234);
    branch(16'hFFFE);
    check("t7_pc_ld", 32'(pc_ld), 32'h1);
    check("t7_override", 32'(pc_ld_data), 32'hFFFE);
    wait_start("t7_a");
    check("t7_addr_a", 32'(mem_addr), 32'hFFFE);
    wait_start("t7_b");
    check("t7_addr_b", 32'(mem_addr), 32'hFFFF);
    wait_start("t7_c");
    check("t7_addr_wrap", 32'(mem_addr), 32'h0000);

    // Randomized traffic against the model.
    lat_rand = 1;
    for (int i = 0; i < 2000; i++) begin
      ir_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 11) == 0) begin
        branch_valid = 1'b1;
        branch_target = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
